tune_replay_player: RTL and testbench



---
 rtl/tune_replay_player.sv | 165 ++++++++++++++++
 tb/tb_tune_replay_player.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tune_replay_player.sv
// tune_replay_player: reads recorded 8-bit key codes one per note slot and
// renders each as a square-wave tone on audio_out until an end marker, the
// last address, or an explicit stop.
module tune_replay_player #(
    parameter int CLK_HZ   = 5000000,
    parameter int TICK_DIV = 312500,
    parameter int ADDR_W   = 7
) (
    input  logic              clk_5MHz,
    input  logic              reset,
    input  logic              play_start,
    input  logic              play_stop,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        current_code,
    output logic              audio_out
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // The fetch overhead is three cycles, so a slot shorter than four cycles
    // would let a tick land outside PLAY. The half-period table assumes CLK_HZ.
    generate
        if (TICK_DIV < 4 || CLK_HZ < TICK_DIV) begin : g_bad_params
            $error("tune_replay_player: TICK_DIV must be >= 4 and <= CLK_HZ");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, PLAY, DONE} state_t;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [14:0]       tone_cnt;
    logic [14:0]       half_per;
    logic              rest_q;
    logic              tick;
    logic              clear;

    // Octave-0 half-periods in clk_5MHz cycles, C..B.
    function automatic logic [14:0] base_half(input logic [3:0] semi);
        case (semi)
            4'd0:    base_half = 15'd19111;
            4'd1:    base_half = 15'd18039;
            4'd2:    base_half = 15'd17026;
            4'd3:    base_half = 15'd16071;
            4'd4:    base_half = 15'd15169;
            4'd5:    base_half = 15'd14317;
            4'd6:    base_half = 15'd13514;
            4'd7:    base_half = 15'd12755;
            4'd8:    base_half = 15'd12039;
            4'd9:    base_half = 15'd11364;
            4'd10:   base_half = 15'd10726;
            4'd11:   base_half = 15'd10124;
            default: base_half = 15'd0;
        endcase
    endfunction

    // Anything that is not a playable note (0x80, bad semitone/octave,
    // bit7 set) is silent.
    function automatic logic code_is_rest(input logic [7:0] code);
        return code[7] || (code[3:0] > 4'd11) || (code[6:4] > 3'd4);
    endfunction

    assign tick  = (tick_cnt == TICK_LAST);
    assign clear = reset || (play_stop && state != IDLE);

    // State register.
    always_ff @(posedge clk_5MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and strobe outputs; stop wins over everything else.
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (play_start && !play_stop) state_nxt = FETCH;
            FETCH: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = (mem_rdata == 8'h00) ? DONE : PLAY;
            end
            PLAY: begin
                busy = 1'b1;
                if (tick) state_nxt = (mem_addr == ADDR_LAST) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (play_stop && state != IDLE) state_nxt = IDLE;
    end

    // Slot timer, address, tone generator and code register.
    always_ff @(posedge clk_5MHz) begin
        if (clear) begin
            mem_addr     <= '0;
            tick_cnt     <= '0;
            tone_cnt     <= '0;
            half_per     <= '0;
            rest_q       <= 1'b1;
            current_code <= 8'h00;
            audio_out    <= 1'b0;
        end else begin
            // Slot timer runs through fetch overhead so slots stay TICK_DIV apart.
            if (state == FETCH || state == WAIT || state == LOAD || state == PLAY)
                tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            case (state)
                IDLE: begin
                    if (play_start && !play_stop) begin
                        mem_addr <= '0;
                        tick_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (mem_rdata != 8'h00) begin
                        current_code <= mem_rdata;
                        half_per     <= base_half(mem_rdata[3:0]) >> mem_rdata[6:4];
                        rest_q       <= code_is_rest(mem_rdata);
                        tone_cnt     <= '0;
                        audio_out    <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        tone_cnt  <= '0;
                        audio_out <= 1'b0;
                        if (mem_addr != ADDR_LAST) mem_addr <= mem_addr + ADDR_W'(1);
                    end else if (tone_cnt == half_per - 15'd1) begin
                        tone_cnt  <= '0;
                        audio_out <= rest_q ? 1'b0 : ~audio_out;
                    end else begin
                        tone_cnt <= tone_cnt + 15'd1;
                    end
                end
                DONE: begin
                    mem_addr     <= '0;
                    tick_cnt     <= '0;
                    current_code <= 8'h00;
                    audio_out    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tune_replay_player.sv
// Bench for tune_replay_player: three instances with different slot lengths
// (long for audible tone periods, medium for directed/random runs, short for
// end-of-memory), each with its own RAM, checked cycle by cycle against a
// slot-arithmetic reference model.
module tb_tune_replay_player;

    localparam int ADDR_W = 7;
    localparam int T_SLOW = 12000;
    localparam int T_MED  = 1250;
    localparam int T_FAST = 8;

    logic clk_5MHz = 1'b0;
    always #5 clk_5MHz = ~clk_5MHz;

    logic              reset;
    logic [2:0]        play_start;
    logic [2:0]        play_stop;
    wire  [2:0]        mem_rd_en;
    wire  [2:0]        busy;
    wire  [2:0]        done;
    wire  [2:0]        audio_out;
    wire  [ADDR_W-1:0] mem_addr [3];
    wire  [7:0]        current_code [3];
    logic [7:0]        rdata_q [3];
    logic [7:0]        mem [3][128];

    int n_assert = 0;
    int n_fail   = 0;

    int tbl [12] = '{19111, 18039, 17026, 16071, 15169, 14317,
                     13514, 12755, 12039, 11364, 10726, 10124};

    tune_replay_player #(.TICK_DIV(T_SLOW), .ADDR_W(ADDR_W)) dut_slow (
        .clk_5MHz(clk_5MHz), .reset(reset), .play_start(play_start[0]), .play_stop(play_stop[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(rdata_q[0]),
        .busy(busy[0]), .done(done[0]), .current_code(current_code[0]), .audio_out(audio_out[0]));

    tune_replay_player #(.TICK_DIV(T_MED), .ADDR_W(ADDR_W)) dut_med (
        .clk_5MHz(clk_5MHz), .reset(reset), .play_start(play_start[1]), .play_stop(play_stop[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(rdata_q[1]),
        .busy(busy[1]), .done(done[1]), .current_code(current_code[1]), .audio_out(audio_out[1]));

    tune_replay_player #(.TICK_DIV(T_FAST), .ADDR_W(ADDR_W)) dut_fast (
        .clk_5MHz(clk_5MHz), .reset(reset), .play_start(play_start[2]), .play_stop(play_stop[2]),
        .mem_rd_en(mem_rd_en[2]), .mem_addr(mem_addr[2]), .mem_rdata(rdata_q[2]),
        .busy(busy[2]), .done(done[2]), .current_code(current_code[2]), .audio_out(audio_out[2]));

    // Synchronous-read RAMs: data appears the cycle after the strobe and holds.
    always @(posedge clk_5MHz)
        for (int k = 0; k < 3; k++)
            if (mem_rd_en[k]) rdata_q[k] <= mem[k][mem_addr[k]];

    function automatic bit is_rest(input logic [7:0] c);
        return (c[7] == 1'b1) || (int'(c[3:0]) > 11) || (int'(c[6:4]) > 4);
    endfunction

    function automatic int half_of(input logic [7:0] c);
        return tbl[int'(c[3:0])] >> int'(c[6:4]);
    endfunction

    function automatic logic [18:0] obs(input int k);
        return {busy[k], done[k], mem_rd_en[k], mem_addr[k], current_code[k], audio_out[k]};
    endfunction

    // Expected outputs c cycles after the play_start edge, from slot arithmetic.
    function automatic logic [18:0] model(input int k, input int T, input int c,
                                          input int done_c, input int dn_addr,
                                          input logic [7:0] dn_code);
        int s, r;
        logic [7:0] cd;
        logic a;
        if (c > done_c) return 19'd0;
        if (c == done_c) return {1'b0, 1'b1, 1'b0, 7'(dn_addr), dn_code, 1'b0};
        s  = c / T;
        r  = c % T;
        cd = (r >= 3) ? mem[k][s] : ((s == 0) ? 8'h00 : mem[k][s-1]);
        a  = 1'b0;
        if (r >= 3 && !is_rest(mem[k][s])) a = (((r - 3) / half_of(mem[k][s])) % 2) == 1;
        return {1'b1, 1'b0, (r == 0), 7'(s), cd, a};
    endfunction

    task automatic pulse_start(input int k);
        play_start[k] = 1'b1;
        @(negedge clk_5MHz);
        play_start[k] = 1'b0;
    endtask

    // Start replay on instance k and compare every cycle until idle again.
    task automatic run_play(input int k, input int T, input string tag);
        int done_c, dn_addr, c;
        logic [7:0] dn_code;
        logic [18:0] e;
        bit bad;
        done_c = -1;
        dn_addr = 0;
        dn_code = 8'h00;
        for (int s = 0; s < 128; s++)
            if (done_c < 0 && mem[k][s] == 8'h00) begin
                done_c  = s * T + 3;
                dn_addr = s;
                dn_code = (s == 0) ? 8'h00 : mem[k][s-1];
            end
        if (done_c < 0) begin
            done_c  = 128 * T;
            dn_addr = 127;
            dn_code = mem[k][127];
        end
        pulse_start(k);
        bad = 1'b0;
        for (c = 0; c <= done_c + 2; c++) begin
            if (c > 0) @(negedge clk_5MHz);
            if (!bad) begin
                e = model(k, T, c, done_c, dn_addr, dn_code);
                n_assert++;
                assert (obs(k) === e) else begin
                    n_fail++;
                    bad = 1'b1;
                    $error("FAIL %s cycle %0d: {busy,done,rd,addr,code,audio} got %h expected %h",
                           tag, c, obs(k), e);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_mem(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        for (int i = 0; i < 128; i++) mem[k][i] = 8'h00;
        mem[k][0] = a;
        mem[k][1] = b;
        mem[k][2] = c;
    endtask

    function automatic logic [7:0] rand_code();
        int sel;
        logic [7:0] c;
        sel = $urandom_range(0, 9);
        if (sel < 5)      c = 8'h40 | 8'($urandom_range(0, 11));
        else if (sel < 7) c = 8'($urandom_range(0, 3) << 4) | 8'($urandom_range(0, 11));
        else if (sel == 7) c = 8'h80;
        else if (sel == 8) c = 8'h80 | 8'($urandom_range(1, 127));
        else              c = 8'($urandom_range(5, 7) << 4) | 8'($urandom_range(0, 15));
        if (c == 8'h00) c = 8'h80;
        return c;
    endfunction

    initial begin
        int dn;
        int len;
        reset      = 1'b1;
        play_start = '0;
        play_stop  = '0;
        for (int k = 0; k < 3; k++) begin
            rdata_q[k] = 8'h00;
            for (int i = 0; i < 128; i++) mem[k][i] = 8'h00;
        end
        repeat (3) @(negedge clk_5MHz);
        for (int k = 0; k < 3; k++) check($sformatf("reset_state%0d", k), obs(k), 19'd0);
        reset = 1'b0;
        @(negedge clk_5MHz);

        // Two notes then end marker on the long-slot instance.
        load_mem(0, 8'h10, 8'h09, 8'h00);
        run_play(0, T_SLOW, "playback_order");

        // No end marker: must stop at the last address without wrapping.
        for (int i = 0; i < 128; i++) mem[2][i] = 8'h01;
        run_play(2, T_FAST, "end_of_memory");

        // Rest and invalid codes.
        load_mem(1, 8'h80, 8'h00, 8'h00);
        run_play(1, T_MED, "rest");
        load_mem(1, 8'h7C, 8'h00, 8'h00);
        run_play(1, T_MED, "invalid_7C");
        load_mem(1, 8'h8F, 8'h00, 8'h00);
        run_play(1, T_MED, "invalid_8F");

        // Random tunes.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 128; i++) mem[1][i] = 8'h00;
            len = $urandom_range(2, 5);
            for (int i = 0; i < len; i++) mem[1][i] = rand_code();
            run_play(1, T_MED, $sformatf("random%0d", r));
        end

        // Stop and start together while idle: stop wins.
        play_start[1] = 1'b1;
        play_stop[1]  = 1'b1;
        @(negedge clk_5MHz);
        play_start[1] = 1'b0;
        play_stop[1]  = 1'b0;
        check("stop_beats_start", obs(1), 19'd0);

        // Abort during the second note.
        load_mem(1, 8'h45, 8'h47, 8'h00);
        pulse_start(1);
        repeat (T_MED + 103) @(negedge clk_5MHz);
        check("abort_pre", {busy[1], mem_addr[1], current_code[1]}, {3'b000, 1'b1, 7'd1, 8'h47});
        play_stop[1] = 1'b1;
        @(negedge clk_5MHz);
        play_stop[1] = 1'b0;
        check("abort_cleared", obs(1), 19'd0);
        dn = 0;
        repeat (3 * T_MED) begin
            @(negedge clk_5MHz);
            if (done[1]) dn++;
        end
        check("abort_no_done", 19'(dn), 19'd0);

        // Start while busy is ignored; reset mid-PLAY clears everything.
        pulse_start(1);
        repeat (T_MED + 50) @(negedge clk_5MHz);
        pulse_start(1);
        @(negedge clk_5MHz);
        check("start_while_busy", {busy[1], mem_addr[1]}, {11'd0, 1'b1, 7'd1});
        repeat (150) @(negedge clk_5MHz);
        reset = 1'b1;
        @(negedge clk_5MHz);
        reset = 1'b0;
        check("reset_mid_play", obs(1), 19'd0);
        @(negedge clk_5MHz);
        run_play(1, T_MED, "replay_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
